// File: rtl/csa_multiplier.sv
// Unsigned WIDTH x WIDTH carry-save array multiplier with a registered product.
// Each CSA row retires one low product bit; a ripple adder merges the leftover sum/carry.
module csa_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned RW = 2 * WIDTH;

    logic [WIDTH-1:0] sum_v;
    logic [WIDTH-1:0] carry_v;
    logic [WIDTH-1:0] pp_row;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] carry_n;
    logic [WIDTH-1:0] lo_bits;
    logic [WIDTH-1:0] hi_bits;
    logic             ripple;
    logic [RW-1:0]    product_c;

    // Sum vectors are kept aligned to the current row's weight, so the previous
    // sum shifts down by one while each carry lands on the next position.
    always_comb begin
        sum_v   = multiplicand & {WIDTH{multiplier[0]}};
        carry_v = '0;
        pp_row  = '0;
        sum_sh  = '0;
        carry_n = '0;
        lo_bits = '0;
        hi_bits = '0;
        ripple  = 1'b0;
        for (int i = 1; i < int'(WIDTH); i++) begin
            lo_bits[i-1] = sum_v[0];
            pp_row       = multiplicand & {WIDTH{multiplier[i]}};
            sum_sh       = sum_v >> 1;
            carry_n      = (pp_row & sum_sh) | (pp_row & carry_v) | (sum_sh & carry_v);
            sum_v        = pp_row ^ sum_sh ^ carry_v;
            carry_v      = carry_n;
        end
        lo_bits[WIDTH-1] = sum_v[0];
        sum_sh = sum_v >> 1;
        // Final carry-propagate adder; the product always fits, so no carry out.
        for (int k = 0; k < int'(WIDTH); k++) begin
            hi_bits[k] = sum_sh[k] ^ carry_v[k] ^ ripple;
            ripple     = (sum_sh[k] & carry_v[k]) | (sum_sh[k] & ripple) | (carry_v[k] & ripple);
        end
        product_c = {hi_bits, lo_bits};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= product_c;
            end
        end
    end

endmodule

// File: tb/tb_csa_multiplier.sv
// Directed and exhaustive checks of csa_multiplier with an expected-result queue.
module tb_csa_multiplier;

    localparam int unsigned W  = 4;
    localparam int unsigned RW = 2 * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          out_valid;
    logic [RW-1:0] result;

    int tests;
    int fails;
    logic [RW-1:0] sb[$];
    logic [RW-1:0] held;

    csa_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then check what the capturing edge produced.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [RW-1:0] exp;
        in_valid     = v;
        multiplicand = a;
        multiplier   = b;
        if (v) sb.push_back(RW'(int'(a) * int'(b)));
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(v));
        if (v) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'(0), 32'(1));
            end else begin
                exp  = sb.pop_front();
                held = exp;
                chk("result", 32'(result), 32'(exp));
            end
        end else begin
            chk("hold", 32'(result), 32'(held));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        held  = '0;
        rst          = 1'b1;
        in_valid     = 1'b1;
        multiplicand = 4'd5;
        multiplier   = 4'd5;

        // Reset held across two edges with valid operands present
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            chk("rst_result", 32'(result), 32'h0);
            chk("rst_valid", 32'(out_valid), 32'h0);
        end
        rst = 1'b0;
        step(1'b1, 4'd5, 4'd5);

        // Back-to-back basic products
        step(1'b1, 4'b1010, 4'b1110);
        step(1'b1, 4'd2, 4'd6);
        step(1'b1, 4'd1, 4'd13);

        // Corners
        step(1'b1, 4'd15, 4'd15);
        step(1'b1, 4'd0, 4'd15);
        step(1'b1, 4'd15, 4'd0);
        step(1'b1, 4'd15, 4'd1);

        // Hold with changed operands
        step(1'b1, 4'd7, 4'd9);
        step(1'b0, 4'd3, 4'd3);

        // Asynchronous reset between edges discards 12*11
        in_valid     = 1'b1;
        multiplicand = 4'd12;
        multiplier   = 4'd11;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_result", 32'(result), 32'h0);
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        held     = '0;
        step(1'b0, 4'd12, 4'd11);
        step(1'b0, 4'd12, 4'd11);

        // Exhaustive stream
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                step(1'b1, W'(a), W'(b));
            end
        end
        step(1'b0, 4'd0, 4'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
